// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
package otter_lsu_pkg;

  typedef enum logic [2:0] {IDLE, RD_EN, RD_CAP, WR, ERR} lsu_state_t;

  localparam logic [1:0] LSU_SZ_BYTE = 2'd0;
  localparam logic [1:0] LSU_SZ_HALF = 2'd1;
  localparam logic [1:0] LSU_SZ_WORD = 2'd2;

endpackage

// File: rtl/otter_lsu_align.sv
// Combinational misalignment detector: half on odd byte, word off a word
// boundary, and the reserved size 3 are all flagged.
module otter_lsu_align
  import otter_lsu_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  output logic       misaligned
);

  assign misaligned = ((size == LSU_SZ_HALF) && addr[0])
                   || ((size == LSU_SZ_WORD) && (addr != 2'b00))
                   || (size == 2'd3);

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit: one access at a time to a sync-read memory port.
// Define OTTER_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h00010000
) (
  input  logic        LSU_CLK,
  input  logic        LSU_RST_N,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WDATA,
  input  logic [1:0]  LSU_SIZE,
  input  logic        LSU_SIGN,
  output logic        LSU_BUSY,
  output logic        LSU_DONE,
  output logic [31:0] LSU_RDATA,
  output logic        LSU_ERR,
  output logic        LSU_IO,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

`ifdef OTTER_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t state, state_nxt;
  logic misaligned, accept;
  logic rden_nxt, we_nxt, done_nxt;

  otter_lsu_align u_align (
    .addr       (LSU_ADDR[1:0]),
    .size       (LSU_SIZE),
    .misaligned (misaligned)
  );

  assign accept   = (state == IDLE) && LSU_REQ;
  assign LSU_BUSY = (state != IDLE);

  always_ff @(posedge LSU_CLK or negedge LSU_RST_N) begin
    if (!LSU_RST_N) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (LSU_REQ) begin
          if (TRAP_EN && misaligned) state_nxt = ERR;
          else if (LSU_WE)           state_nxt = WR;
          else                       state_nxt = RD_EN;
        end
      end
      RD_EN:          state_nxt = RD_CAP;
      RD_CAP, WR, ERR: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the state being entered.
  always_comb begin
    rden_nxt = (state_nxt == RD_EN);
    we_nxt   = (state_nxt == WR);
    done_nxt = (state == RD_CAP) || (state == WR) || (state == ERR);
  end

  always_ff @(posedge LSU_CLK or negedge LSU_RST_N) begin
    if (!LSU_RST_N) begin
      MEM_RDEN2 <= 1'b0;
      MEM_WE2   <= 1'b0;
      MEM_ADDR2 <= '0;
      MEM_DIN2  <= '0;
      MEM_SIZE  <= '0;
      MEM_SIGN  <= 1'b0;
      LSU_DONE  <= 1'b0;
      LSU_RDATA <= '0;
      LSU_IO    <= 1'b0;
    end else begin
      MEM_RDEN2 <= rden_nxt;
      MEM_WE2   <= we_nxt;
      LSU_DONE  <= done_nxt;
      if (accept) begin
        MEM_ADDR2 <= LSU_ADDR;
        MEM_DIN2  <= LSU_WDATA;
        MEM_SIZE  <= LSU_SIZE;
        MEM_SIGN  <= LSU_SIGN;
        LSU_IO    <= (LSU_ADDR >= IO_BASE);
      end
      if (state == RD_CAP) LSU_RDATA <= MEM_DOUT2;
    end
  end

`ifdef OTTER_LSU_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge LSU_CLK or negedge LSU_RST_N) begin
    if (!LSU_RST_N) err_q <= 1'b0;
    else            err_q <= (state == ERR);
  end
  assign LSU_ERR = err_q;
`else
  assign LSU_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_otter_lsu.sv
// Scoreboard bench for otter_lsu with a behavioural sync-read byte memory.
module tb_otter_lsu;

`ifdef OTTER_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = '0;
  logic        busy, done, err, io, rden2, we2, msign;
  logic [31:0] rdata, maddr, din;
  logic [1:0]  msize;
  logic [31:0] dout = '0;

  otter_lsu dut (
    .LSU_CLK(clk), .LSU_RST_N(rst_n), .LSU_REQ(req), .LSU_WE(we),
    .LSU_ADDR(addr), .LSU_WDATA(wdata), .LSU_SIZE(size), .LSU_SIGN(sign),
    .LSU_BUSY(busy), .LSU_DONE(done), .LSU_RDATA(rdata), .LSU_ERR(err),
    .LSU_IO(io), .MEM_RDEN2(rden2), .MEM_WE2(we2), .MEM_ADDR2(maddr),
    .MEM_DIN2(din), .MEM_SIZE(msize), .MEM_SIGN(msign), .MEM_DOUT2(dout)
  );

  always #5 clk = ~clk;

  int cyc = 0, rden_cnt = 0, we_cnt = 0;
  int n_chk = 0, n_pass = 0;
  int we_run = 0;
  bit prev_hold = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rden2) rden_cnt <= rden_cnt + 1;
    if (we2)   we_cnt   <= we_cnt + 1;
  end

  // Behavioural memory: little-endian bytes, sized/extended read data one cycle after RDEN2.
  bit [7:0] mem [4096];

  function automatic logic [31:0] rd_model(logic [31:0] a, logic [1:0] sz, logic sg);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mem[a[11:0] + 12'(i)];
    case (sz)
      2'd0:    return sg ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'd1:    return sg ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (we2)
      for (int i = 0; i < ((msize == 2'd0) ? 1 : (msize == 2'd1) ? 2 : 4); i++)
        mem[maddr[11:0] + 12'(i)] <= din[8*i +: 8];
    if (rden2) dout <= rd_model(maddr, msize, msign);
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        err;
    logic        io;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Monitor: every DONE pops one expectation; WE2 must never stay high two cycles.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_done: got done=1 required no pending access");
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_rdata"},   rdata, e.rd);
        chk({e.nm, "_err"},     {31'b0, err}, {31'b0, e.err});
        chk({e.nm, "_io"},      {31'b0, io},  {31'b0, e.io});
        chk({e.nm, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    if (we2) we_run++;
    else if (we_run != 0) begin
      chk("we2_width", 32'(we_run), 32'd1);
      we_run = 0;
    end
  end

  task automatic issue(input string nm, input bit w, input logic [31:0] a, d,
                       input logic [1:0] sz, input bit sg, input bit hold,
                       input logic [31:0] exp_rd, input bit exp_err, exp_io, input int exp_lat);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (busy && t < 50) begin @(negedge clk); t++; end
    if (busy) begin n_chk++; $display("FAIL %s_issue_timeout: busy=1 required 0", nm); end
    if (prev_hold) chk({nm, "_b2b_done"}, {31'b0, done}, 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; size = sz; sign = sg;
    e.nm = nm; e.rd = exp_rd; e.err = exp_err; e.io = exp_io; e.acc = cyc + 1; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    prev_hold = hold;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin n_chk++; $display("FAIL drain_timeout: pending=%0d required 0", sb.size()); end
    @(negedge clk);
  endtask

  initial begin
    int r0, w0;
    logic [31:0] rd_mis;
    rd_mis = TRAP ? 32'h0 : 32'h0000DEAD;

    #1;
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {27'b0, err, io, rden2, we2, msign}, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_din",   din | {30'b0, msize}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue("st_w100", 1, 32'h100, 32'hDEADBEEF, 2'd2, 0, 0, 32'h0, 0, 0, 2);
    issue("ld_w100", 0, 32'h100, 32'h0, 2'd2, 1, 0, 32'hDEADBEEF, 0, 0, 3);
    issue("ld_sb103", 0, 32'h103, 32'h0, 2'd0, 0, 0, 32'hFFFFFFDE, 0, 0, 3);
    issue("ld_ub103", 0, 32'h103, 32'h0, 2'd0, 1, 0, 32'h000000DE, 0, 0, 3);

    // Back-to-back with REQ held high through the first DONE.
    issue("b2b_uh100", 0, 32'h100, 32'h0, 2'd1, 1, 1, 32'h0000BEEF, 0, 0, 3);
    issue("b2b_sh102", 0, 32'h102, 32'h0, 2'd1, 0, 0, 32'hFFFFDEAD, 0, 0, 3);

    // A store raised mid-load must be ignored; the reload proves 0x200 untouched.
    issue("ld_w200", 0, 32'h200, 32'h0, 2'd2, 1, 0, 32'h0, 0, 0, 3);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h200; wdata = 32'h55AA55AA; size = 2'd2;
    @(negedge clk);
    req = 1'b0;
    issue("ld_w200_again", 0, 32'h200, 32'h0, 2'd2, 1, 0, 32'h0, 0, 0, 3);
    drain();

    r0 = rden_cnt;
    issue("mis_w102", 0, 32'h102, 32'h0, 2'd2, 1, 0, rd_mis, TRAP, 0, TRAP ? 2 : 3);
    drain();
    chk("mis_rden2_cycles", 32'(rden_cnt - r0), TRAP ? 32'd0 : 32'd1);

    w0 = we_cnt;
    issue("st_io", 1, 32'h00010004, 32'h12345678, 2'd2, 0, 0, rd_mis, 0, 1, 2);
    drain();
    chk("st_io_we2_cycles", 32'(we_cnt - w0), 32'd1);
    issue("ld_io", 0, 32'h00010004, 32'h0, 2'd2, 1, 0, 32'h12345678, 0, 1, 3);
    drain();

    // Reset in the middle of a WR cycle.
    req = 1'b1; we = 1'b1; addr = 32'h300; wdata = 32'hCAFEF00D; size = 2'd2;
    @(posedge clk); #1;
    req = 1'b0;
    chk("wr_we2_up", {31'b0, we2}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we2_drop", {31'b0, we2}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    issue("ld_w300", 0, 32'h300, 32'h0, 2'd2, 1, 0, 32'h0, 0, 0, 3);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
